// File: rtl/psk_pkg.sv
// Shared types and the symbol-to-phase Gray mapping for the BPSK/QPSK modulator.
package psk_pkg;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_0   = 2'd0;
  localparam phase_t PH_90  = 2'd1;
  localparam phase_t PH_180 = 2'd2;
  localparam phase_t PH_270 = 2'd3;

  // BPSK uses sym[0] only; QPSK sym[1] is the first bit received.
  function automatic phase_t sym_to_phase(input mode_e m, input logic [1:0] sym);
    phase_t ph;
    if (m == MODE_BPSK) begin
      ph = sym[0] ? PH_0 : PH_180;
    end else begin
      case (sym)
        2'b00:   ph = PH_0;
        2'b01:   ph = PH_90;
        2'b11:   ph = PH_180;
        2'b10:   ph = PH_270;
        default: ph = PH_0;
      endcase
    end
    return ph;
  endfunction

endpackage

// File: rtl/psk_phase_select.sv
// Picks +I, +Q, -I or -Q for a phase code; negation saturates the most negative code.
module psk_phase_select
  import psk_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_i,
  input  logic [WIDTH-1:0] q_i,
  input  phase_t           phase_i,
  output logic [WIDTH-1:0] sample_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x == MOST_NEG) begin
      r = MOST_POS;
    end else begin
      r = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  always_comb begin
    sample_o = i_i;
    case (phase_i)
      PH_0:    sample_o = i_i;
      PH_90:   sample_o = q_i;
      PH_180:  sample_o = sat_neg(i_i);
      PH_270:  sample_o = sat_neg(q_i);
      default: sample_o = i_i;
    endcase
  end

endmodule

// File: rtl/psk_modulator.sv
// BPSK/QPSK modulator: serial bit collector, IDLE/SEND symbol FSM with per-symbol
// sample counter, and a registered output stage fed by a registered carrier.
module psk_modulator
  import psk_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SPS   = 8
) (
  input  logic             sychronizer,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] carrier_i,
  input  logic [WIDTH-1:0] carrier_q,
  input  logic             mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] signal_out,
  output logic             sym_strobe,
  output logic             active,
  output logic             underrun
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] CTR_LAST = CW'(SPS - 1);

  logic             rel_q;
  logic [1:0]       buf_q, buf_d;
  logic [1:0]       cnt_q, cnt_d;
  mode_e            bmode_q, bmode_d;
  state_e           state_q, state_d;
  logic [1:0]       sym_q, sym_d;
  mode_e            smode_q, smode_d;
  logic [CW-1:0]    ctr_q, ctr_d;
  logic             urp_q, urp_d;
  logic [WIDTH-1:0] ci_q, cq_q;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             strobe_q, strobe_d;
  logic             active_q, active_d;
  logic             underrun_q;

  logic [1:0]       k_s;
  logic             full_s;
  logic             accept_s;
  logic             last_s;
  logic             load_s;
  logic [WIDTH-1:0] sel_s;

  assign k_s       = (bmode_q == MODE_QPSK) ? 2'd2 : 2'd1;
  assign full_s    = (cnt_q == k_s);
  assign bit_ready = rel_q & ~full_s;
  assign accept_s  = bit_valid & bit_ready;
  assign last_s    = (ctr_q == CTR_LAST);
  assign load_s    = full_s & ((state_q == ST_IDLE) | last_s);

  // A load empties the buffer first, so a bit accepted in the same cycle starts a fresh symbol.
  always_comb begin
    buf_d   = load_s ? 2'b00 : buf_q;
    cnt_d   = load_s ? 2'd0 : cnt_q;
    bmode_d = bmode_q;
    if (accept_s) begin
      if (cnt_d == 2'd0) begin
        bmode_d = mode_e'(mode);
        buf_d   = {1'b0, bit_in};
        cnt_d   = 2'd1;
      end else begin
        buf_d = {buf_d[0], bit_in};
        cnt_d = cnt_d + 2'd1;
      end
    end else begin
      bmode_d = bmode_q;
    end
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    smode_d = smode_q;
    ctr_d   = ctr_q;
    urp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctr_d = '0;
        if (load_s) begin
          state_d = ST_SEND;
          sym_d   = buf_q;
          smode_d = bmode_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!last_s) begin
          ctr_d = ctr_q + CW'(1);
        end else if (full_s) begin
          sym_d   = buf_q;
          smode_d = bmode_q;
          ctr_d   = '0;
        end else begin
          state_d = ST_IDLE;
          ctr_d   = '0;
          urp_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  psk_phase_select #(.WIDTH(WIDTH)) u_sel (
    .i_i      (ci_q),
    .q_i      (cq_q),
    .phase_i  (sym_to_phase(smode_q, sym_q)),
    .sample_o (sel_s)
  );

  always_comb begin
    sig_d    = '0;
    strobe_d = 1'b0;
    active_d = 1'b0;
    if (state_q == ST_SEND) begin
      sig_d    = sel_s;
      strobe_d = (ctr_q == '0);
      active_d = 1'b1;
    end else begin
      sig_d    = '0;
    end
  end

  always_ff @(posedge sychronizer or negedge reset_n) begin
    if (!reset_n) begin
      rel_q   <= 1'b0;
      buf_q   <= 2'b00;
      cnt_q   <= 2'd0;
      bmode_q <= MODE_BPSK;
      state_q <= ST_IDLE;
      sym_q   <= 2'b00;
      smode_q <= MODE_BPSK;
      ctr_q   <= '0;
      urp_q   <= 1'b0;
    end else begin
      rel_q   <= 1'b1;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      state_q <= state_d;
      sym_q   <= sym_d;
      smode_q <= smode_d;
      ctr_q   <= ctr_d;
      urp_q   <= urp_d;
    end
  end

  // Carrier is registered alongside the FSM so the output stage sees a matching pair.
  always_ff @(posedge sychronizer or negedge reset_n) begin
    if (!reset_n) begin
      ci_q       <= '0;
      cq_q       <= '0;
      sig_q      <= '0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ci_q       <= carrier_i;
      cq_q       <= carrier_q;
      sig_q      <= sig_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
      underrun_q <= urp_q;
    end
  end

  assign signal_out = sig_q;
  assign sym_strobe = strobe_q;
  assign active     = active_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_psk_modulator.sv
// Self-checking bench for psk_modulator: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_psk_modulator;
  localparam int W   = 12;
  localparam int SPS = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] ci = '0, cq = '0;
  logic         md = 1'b0, bi = 1'b0, bv = 1'b0;
  logic         br, stb, act, ur;
  logic [W-1:0] so;

  always #5 clk = ~clk;

  psk_modulator #(.WIDTH(W), .SPS(SPS)) dut (
    .sychronizer(clk), .reset_n(rst_n), .carrier_i(ci), .carrier_q(cq),
    .mode(md), .bit_in(bi), .bit_valid(bv), .bit_ready(br),
    .signal_out(so), .sym_strobe(stb), .active(act), .underrun(ur)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending bits, samples left in the current symbol, phase code.
  int m_bits[$];
  int m_k, m_left, m_code, m_pi, m_pq;
  bit m_rel, m_urp;
  int e_sig;
  bit e_stb, e_act, e_ur;
  int gray[4] = '{0, 1, 3, 2};

  logic [W-1:0] log_sig[$];
  bit log_stb[$], log_ur[$], log_act[$];

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ngs(input int x);
    return (x == -2048) ? 2047 : -x;
  endfunction

  function automatic int pval(input int code, input int i, input int q);
    case (code)
      0: return i;
      1: return q;
      2: return ngs(i);
      default: return ngs(q);
    endcase
  endfunction

  function automatic bit m_ready();
    bit full;
    full = (m_bits.size() > 0) && (m_bits.size() == m_k);
    return m_rel && !full;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_k = 1; m_left = 0; m_code = 0; m_pi = 0; m_pq = 0;
    m_rel = 0; m_urp = 0;
    e_sig = 0; e_stb = 0; e_act = 0; e_ur = 0;
  endtask

  task automatic model_edge();
    bit full, acc, was_sending;
    if (m_left > 0) begin
      e_sig = pval(m_code, m_pi, m_pq); e_stb = (m_left == SPS); e_act = 1;
    end else begin
      e_sig = 0; e_stb = 0; e_act = 0;
    end
    e_ur  = m_urp;
    m_urp = 0;
    full  = (m_bits.size() > 0) && (m_bits.size() == m_k);
    acc   = bv && m_rel && !full;
    was_sending = (m_left > 0);
    if (m_left > 0) m_left--;
    if (m_left == 0) begin
      if (full) begin
        if (m_k == 1) m_code = (m_bits[0] == 1) ? 0 : 2;
        else m_code = gray[m_bits[0] * 2 + m_bits[1]];
        m_bits.delete();
        m_left = SPS;
      end else if (was_sending) begin
        m_urp = 1;
      end
    end
    if (acc) begin
      if (m_bits.size() == 0) m_k = md ? 2 : 1;
      m_bits.push_back(int'(bi));
    end
    m_pi  = sx(ci);
    m_pq  = sx(cq);
    m_rel = 1;
  endtask

  task automatic step(input logic b, input logic v, input logic m);
    bi = b; bv = v; md = m;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    total++;
    if (sx(so) != e_sig || stb !== e_stb || act !== e_act || ur !== e_ur || br !== m_ready()) begin
      bad++;
      $display("FAIL cycle %0d: got out=%0d stb=%b act=%b ur=%b rdy=%b, want out=%0d stb=%b act=%b ur=%b rdy=%b",
               cyc, sx(so), stb, act, ur, br, e_sig, e_stb, e_act, e_ur, m_ready());
    end
    log_sig.push_back(so); log_stb.push_back(stb); log_ur.push_back(ur); log_act.push_back(act);
  endtask

  task automatic send_bit(input logic b, input logic m, output int idx);
    bit r;
    idx = -1;
    for (int n = 0; n < 4 * SPS + 10; n++) begin
      r = br;
      step(b, 1'b1, m);
      if (r) begin
        idx = log_sig.size() - 1;
        break;
      end
    end
    bv = 1'b0;
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL send_bit: bit never accepted, got ready=%b want 1", br);
    end
  endtask

  task automatic do_reset();
    bv = 0; bi = 0; md = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (so !== '0 || stb !== 1'b0 || act !== 1'b0 || ur !== 1'b0 || br !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got out=%h stb=%b act=%b ur=%b rdy=%b want all 0", so, stb, act, ur, br);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    log_sig.delete(); log_stb.delete(); log_ur.delete(); log_act.delete();
  endtask

  logic [W-1:0] exv[4];

  task automatic check_stream(input string nm, input int n);
    int i0;
    bit ok;
    i0 = -1;
    for (int i = 0; i < log_sig.size(); i++) if (log_stb[i] && i0 < 0) i0 = i;
    total++;
    if (i0 < 0 || i0 + n * SPS >= log_sig.size()) begin
      bad++;
      $display("FAIL %s: first strobe at %0d of %0d samples, want a full %0d-symbol stream", nm, i0, log_sig.size(), n);
      return;
    end
    for (int s = 0; s < n; s++) begin
      ok = 1;
      for (int k = 0; k < SPS; k++)
        if (log_sig[i0+s*SPS+k] !== exv[s] || log_stb[i0+s*SPS+k] !== (k == 0) || log_ur[i0+s*SPS+k] !== 1'b0) ok = 0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s sym%0d: got first sample %h stb=%b, want %h for %0d samples", nm, s, log_sig[i0+s*SPS], log_stb[i0+s*SPS], exv[s], SPS);
      end
    end
    total++;
    if (log_ur[i0+n*SPS] !== 1'b1 || log_sig[i0+n*SPS] !== '0) begin
      bad++;
      $display("FAIL %s end: got ur=%b out=%h, want ur=1 out=0", nm, log_ur[i0+n*SPS], log_sig[i0+n*SPS]);
    end
  endtask

  typedef struct {
    logic         m;
    logic [1:0]   sym;
    logic [W-1:0] i;
    logic [W-1:0] q;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int idx, i4;
    vecs[0]  = '{1'b0, 2'b01, 12'h3F0, 12'h0C0, 12'h3F0};
    vecs[1]  = '{1'b0, 2'b00, 12'h3F0, 12'h0C0, 12'hC10};
    vecs[2]  = '{1'b0, 2'b00, 12'h800, 12'h0C0, 12'h7FF};
    vecs[3]  = '{1'b0, 2'b01, 12'h800, 12'h0C0, 12'h800};
    vecs[4]  = '{1'b1, 2'b00, 12'h3F0, 12'h0C0, 12'h3F0};
    vecs[5]  = '{1'b1, 2'b01, 12'h3F0, 12'h0C0, 12'h0C0};
    vecs[6]  = '{1'b1, 2'b11, 12'h3F0, 12'h0C0, 12'hC10};
    vecs[7]  = '{1'b1, 2'b10, 12'h3F0, 12'h0C0, 12'hF40};
    vecs[8]  = '{1'b1, 2'b10, 12'h3F0, 12'h800, 12'h7FF};
    vecs[9]  = '{1'b1, 2'b01, 12'h3F0, 12'h800, 12'h800};
    vecs[10] = '{1'b1, 2'b11, 12'h7FF, 12'h0C0, 12'h801};

    model_reset();
    do_reset();

    for (int v = 0; v < 11; v++) begin
      do_reset();
      ci = vecs[v].i; cq = vecs[v].q;
      if (vecs[v].m) begin
        send_bit(vecs[v].sym[1], 1'b1, idx);
        send_bit(vecs[v].sym[0], 1'b1, idx);
      end else begin
        send_bit(vecs[v].sym[0], 1'b0, idx);
      end
      repeat (SPS + 3) step(1'b0, 1'b0, 1'b0);
      exv[0] = vecs[v].exp;
      check_stream($sformatf("vec%0d", v), 1);
    end

    // BPSK 1,0 with valid held: two gapless symbols
    do_reset();
    ci = 12'h3F0; cq = 12'h0C0;
    send_bit(1'b1, 1'b0, idx);
    send_bit(1'b0, 1'b0, idx);
    repeat (2 * SPS + 3) step(1'b0, 1'b0, 1'b0);
    exv[0] = 12'h3F0; exv[1] = 12'hC10;
    check_stream("bpsk_stream", 2);

    // QPSK 00 01 11 10
    do_reset();
    send_bit(1'b0, 1'b1, idx); send_bit(1'b0, 1'b1, idx);
    send_bit(1'b0, 1'b1, idx); send_bit(1'b1, 1'b1, idx);
    send_bit(1'b1, 1'b1, idx); send_bit(1'b1, 1'b1, idx);
    send_bit(1'b1, 1'b1, idx); send_bit(1'b0, 1'b1, idx);
    repeat (4 * SPS + 3) step(1'b0, 1'b0, 1'b1);
    exv[0] = 12'h3F0; exv[1] = 12'h0C0; exv[2] = 12'hC10; exv[3] = 12'hF40;
    check_stream("qpsk_stream", 4);

    // Starvation: 3 QPSK bits, then the 4th completes "10" two cycles after acceptance
    do_reset();
    send_bit(1'b0, 1'b1, idx); send_bit(1'b1, 1'b1, idx); send_bit(1'b1, 1'b1, idx);
    repeat (SPS + 4) step(1'b0, 1'b0, 1'b0);
    exv[0] = 12'h0C0;
    check_stream("starve", 1);
    send_bit(1'b0, 1'b0, i4);
    repeat (SPS + 3) step(1'b0, 1'b0, 1'b0);
    total++;
    if (i4 < 0 || log_act[i4+1] !== 1'b0 || log_stb[i4+2] !== 1'b1 || log_sig[i4+2] !== 12'hF40) begin
      bad++;
      $display("FAIL resume: got act@+1=%b stb@+2=%b out@+2=%h, want 0 1 f40",
               (i4 >= 0) ? log_act[i4+1] : 1'b1, (i4 >= 0) ? log_stb[i4+2] : 1'b0, (i4 >= 0) ? log_sig[i4+2] : 12'h0);
    end

    // Mode toggled mid-symbol: first symbol stays BPSK, next collects two bits
    do_reset();
    send_bit(1'b1, 1'b0, idx);
    step(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, idx);
    send_bit(1'b1, 1'b0, idx);
    repeat (2 * SPS + 3) step(1'b0, 1'b0, 1'b0);
    exv[0] = 12'h3F0; exv[1] = 12'h0C0;
    check_stream("mode_switch", 2);

    // Reset at sample 3 with a partial QPSK bit buffered
    do_reset();
    send_bit(1'b1, 1'b0, idx);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, idx);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    send_bit(1'b0, 1'b0, idx);
    repeat (SPS + 3) step(1'b0, 1'b0, 1'b0);
    exv[0] = 12'hC10;
    check_stream("reset_empty", 1);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ci = ($urandom_range(7) == 0) ? 12'h800 : W'($urandom);
      cq = ($urandom_range(7) == 0) ? 12'h800 : W'($urandom);
      if (n == 1500) do_reset();
      step(1'($urandom), ($urandom_range(9) < 6), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
